// File: rtl/matrix_load8_if.sv
// Stream-in / matrix-out bundle for matrix_load8.
// slave is the loader's view; master is the producer/consumer side.
interface matrix_load8_if #(
   parameter int unsigned width = 16
);
   logic                              s_valid;
   logic [2*width-1:0]                s_data;
   logic                              s_last;
   logic                              s_ready;
   logic [4:0]                        m_bit1_in;
   logic [4:0]                        m_bit2_in;
   logic [7:0][7:0][2*width-1:0]      A;
   logic [7:0][7:0][2*width-1:0]      B;
   logic [4:0]                        m_bit1;
   logic [4:0]                        m_bit2;
   logic                              mat_valid;
   logic                              mat_ack;
   logic                              frame_err;

   modport slave (
      input  s_valid, s_data, s_last, m_bit1_in, m_bit2_in, mat_ack,
      output s_ready, A, B, m_bit1, m_bit2, mat_valid, frame_err
   );

   modport master (
      output s_valid, s_data, s_last, m_bit1_in, m_bit2_in, mat_ack,
      input  s_ready, A, B, m_bit1, m_bit2, mat_valid, frame_err
   );
endinterface

// File: rtl/matrix_load8.sv
// Loads a 128-beat stream into two 8x8 operand matrices (A then B) and holds them until acked.
// Optional s_last framing check enabled by defining MATRIX_LOAD8_LAST_CHK_EN.
module matrix_load8 #(
   parameter int unsigned width = 16
) (
   input logic           clk,
   input logic           rst_n,
   matrix_load8_if.slave bus
);

   typedef enum logic [1:0] {StLoadA, StLoadB, StHold} state_e;

   state_e                         state_q;
   logic [5:0]                     idx_q;
   logic                           s_ready_q;
   logic                           mat_valid_q;
   logic [4:0]                     m_bit1_q;
   logic [4:0]                     m_bit2_q;
   logic [7:0][7:0][2*width-1:0]   a_q;
   logic [7:0][7:0][2*width-1:0]   b_q;
   logic                           beat;

   // s_ready_q mirrors (state_q != StHold), so a beat is just valid while ready.
   assign beat = bus.s_valid & s_ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StLoadA;
         idx_q       <= 6'd0;
         s_ready_q   <= 1'b1;
         mat_valid_q <= 1'b0;
         m_bit1_q    <= 5'd0;
         m_bit2_q    <= 5'd0;
         a_q         <= '0;
         b_q         <= '0;
      end else begin
         case (state_q)
            StLoadA: begin
               if (beat) begin
                  a_q[idx_q[5:3]][idx_q[2:0]] <= bus.s_data;
                  if (idx_q == 6'd0) begin
                     m_bit1_q <= bus.m_bit1_in;
                     m_bit2_q <= bus.m_bit2_in;
                  end
                  idx_q <= idx_q + 6'd1;
                  if (idx_q == 6'd63) state_q <= StLoadB;
               end
            end
            StLoadB: begin
               if (beat) begin
                  b_q[idx_q[5:3]][idx_q[2:0]] <= bus.s_data;
                  idx_q <= idx_q + 6'd1;
                  if (idx_q == 6'd63) begin
                     state_q     <= StHold;
                     s_ready_q   <= 1'b0;
                     mat_valid_q <= 1'b1;
                  end
               end
            end
            StHold: begin
               if (bus.mat_ack) begin
                  state_q     <= StLoadA;
                  s_ready_q   <= 1'b1;
                  mat_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= StLoadA;
               idx_q       <= 6'd0;
               s_ready_q   <= 1'b1;
               mat_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s_ready   = s_ready_q;
   assign bus.mat_valid = mat_valid_q;
   assign bus.m_bit1    = m_bit1_q;
   assign bus.m_bit2    = m_bit2_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;

`ifdef MATRIX_LOAD8_LAST_CHK_EN
   logic frame_err_q;
   logic final_beat;

   assign final_beat = (state_q == StLoadB) && (idx_q == 6'd63);

   // Sticky: flags both an early s_last and a missing one on the final beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_q <= 1'b0;
      end else if (beat && (bus.s_last != final_beat)) begin
         frame_err_q <= 1'b1;
      end
   end

   assign bus.frame_err = frame_err_q;
`else
   assign bus.frame_err = 1'b0;
`endif

endmodule

// File: doc/matrix_load8.md
MATRIX_LOAD8 -- requirements
Module: matrix_load8

Interface
REQ-001 Parameter: width, 16, element half-width; every element is 2*width bits.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 s_valid  input  1  stream beat valid.
REQ-005 s_data  input  2*width  stream element.
REQ-006 s_last  input  1  marks final beat of a 128-beat frame.
REQ-007 s_ready  output  1  loader can accept a beat.
REQ-008 m_bit1_in, m_bit2_in  input  5 each  per-frame format configuration.
REQ-009 A  output  [2*width-1:0] [7:0][7:0]  assembled operand A, row-major.
REQ-010 B  output  [2*width-1:0] [7:0][7:0]  assembled operand B, row-major.
REQ-011 m_bit1, m_bit2  output  5 each  configuration latched for the held frame.
REQ-012 mat_valid  output  1  A, B, m_bit1 and m_bit2 are complete and stable.
REQ-013 mat_ack  input  1  downstream multiplier has consumed the held frame.
REQ-014 frame_err  output  1  sticky s_last framing error (macro only; tied 0 otherwise).

Function
REQ-015 A beat SHALL transfer only on a rising edge with s_valid=1 and s_ready=1.
REQ-016 FSM states SHALL be LOAD_A, LOAD_B and HOLD, with LOAD_A as the reset state.
REQ-017 A 6-bit index SHALL address beats in row-major order: element [idx[5:3]][idx[2:0]].
REQ-018 In LOAD_A, each beat SHALL write A[idx]; after index 63 the FSM SHALL go to LOAD_B and idx SHALL wrap to 0.
REQ-019 In LOAD_B, each beat SHALL write B[idx]; after index 63 the FSM SHALL go to HOLD.
REQ-020 m_bit1_in and m_bit2_in SHALL be latched into m_bit1 and m_bit2 on the first beat of LOAD_A (idx 0) only.
REQ-021 s_ready SHALL be 1 in LOAD_A and LOAD_B, and 0 in HOLD.
REQ-022 mat_valid SHALL be 1 exactly while in HOLD, asserting the cycle after the 128th accepted beat.
REQ-023 In HOLD, A, B, m_bit1 and m_bit2 SHALL NOT change.
REQ-024 mat_ack=1 in HOLD SHALL move the FSM to LOAD_A next cycle, with s_ready=1 and mat_valid=0 that cycle.
REQ-025 mat_ack outside HOLD SHALL be ignored.
REQ-026 s_valid while s_ready=0 SHALL be ignored; no data is captured and the index does not advance.
REQ-027 Stalls (s_valid=0) mid-frame SHALL preserve the index and all already-written elements.
REQ-028 A and B SHALL retain the previous frame's contents until overwritten element by element.

Reset
REQ-029 rst_n=0 SHALL immediately force the following, regardless of clock:
- FSM = LOAD_A, idx = 0
- mat_valid = 0, frame_err = 0
- m_bit1 = 0, m_bit2 = 0
- all A and B elements = 0
REQ-030 A reset during LOAD_A, LOAD_B or HOLD SHALL discard any partial or held frame.
REQ-031 After rst_n deasserts, s_ready SHALL be 1 on the first clock edge.

Configuration
REQ-032 Macro MATRIX_LOAD8_LAST_CHK_EN, when defined:
- frame_err SHALL set when s_last=1 on any beat other than B index 63.
- frame_err SHALL also set when s_last=0 on B index 63.
- frame_err stays set until reset; loading continues unaffected.
REQ-033 Without MATRIX_LOAD8_LAST_CHK_EN, s_last SHALL be ignored, frame_err SHALL be constant 0, and no check logic is instantiated.

Verification
REQ-034 Full frame: stream values 0..127 back-to-back (s_last on beat 127) with m_bit1_in=5, m_bit2_in=10.
- Expect mat_valid the cycle after beat 127.
- Expect A[i][j]=8i+j, B[i][j]=64+8i+j, m_bit1=5, m_bit2=10.
REQ-035 Backpressure: hold s_valid=1 after the frame.
- Expect s_ready=0 and contents unchanged for 20 cycles.
- Pulse mat_ack: next cycle s_ready=1, mat_valid=0; the next beat writes A[0][0].
REQ-036 Stalls: insert random s_valid gaps within one frame.
- Expect the same contents as REQ-034 and exactly 128 accepted beats.
REQ-037 Reset mid-frame: assert rst_n=0 after 70 beats.
- Expect all outputs 0 and s_ready=1.
- A new full frame loads correctly from A[0][0].
REQ-038 Macro defined: s_last=1 on beat 50 sets frame_err, which stays 1 through HOLD; a clean frame with the macro undefined keeps frame_err=0.
REQ-039 Stray ack: mat_ack=1 during LOAD_B beat 10 has no effect; the frame completes normally.
